la_matrix_stream: RTL and testbench
===================================

# la_matrix_stream

Parametrised N×N matrix buffer that succeeds the fixed 5×5 address-indexed matrix blocks in the linear-algebra datapath. It accepts a matrix as a row-major word stream with a valid/ready handshake and computes the trace while loading. It then replays the matrix downstream in row-major, transposed (column-major) or diagonal-only order under valid/ready backpressure. An address-indexed registered read port (`address`/`data_out`) stays available in every state for debug and random access.

## Interface
- `N`, 5, matrix dimension (N ≥ 2)
- `W`, 32, element width in bits
- `AW`, 5, address width; must satisfy 2^AW ≥ N·N
- `TW`, 3, trace guard bits; trace width is W+TW

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous abort: return to LOAD from any state
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  input accepted this cycle when `in_valid & in_ready`
- `in_data`  in  W  matrix element, row-major order
- `start`  in  1  one-cycle pulse that begins a replay; sampled only in FULL
- `mode`  in  2  replay order, latched on `start`: 0 row-major, 1 column-major, 2 diagonal, 3 reserved (treated as 0)
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  W  replay element
- `out_last`  out  1  marks the final word of a replay
- `full`  out  1  high in FULL and STREAM
- `busy`  out  1  high in STREAM
- `trace`  out  W+TW  sum of diagonal elements, unsigned, wraps mod 2^(W+TW)
- `address`  in  AW  random-access read address, row-major index
- `data_out`  out  W  registered read data

## Operation
- Storage is an N·N register array with async reset to 0. A row-major index is row·N+col.
- FSM states: LOAD, FULL, STREAM.
- LOAD:
  - `in_ready`=1.
  - Each accepted word is written to `mem[wr_ptr]` and `wr_ptr` increments.
  - Row/col counters track the write position. When row==col, the word is added to `trace`.
  - Accepting word N·N−1 moves the FSM to FULL.
  - `start` is ignored in LOAD.
- FULL:
  - `in_ready`=0; `full`=1.
  - `start` latches `mode`, zeroes the replay counters and moves the FSM to STREAM.
- STREAM:
  - `out_valid`=1 and `out_data` = `mem[rd_idx]`, combinational from the array.
  - The index advances only on `out_valid & out_ready`. `out_data` is held stable while stalled.
  - Mode 0: rd_idx = r·N+c, with c as the inner counter.
  - Mode 1: rd_idx = c·N+r, with the same counter walk, which yields the transpose.
  - Mode 2: rd_idx = k·(N+1) for k = 0..N−1.
  - `out_last`=1 on word N·N−1 (modes 0/1) or word N−1 (mode 2).
  - The handshake on the last word moves the FSM to LOAD, zeroes `wr_ptr` and zeroes `trace`.
  - `start` is ignored in STREAM.
- `clear` has priority over every other event. The next state is LOAD, pointers and `trace` go to 0, and `out_valid` drops. Memory contents are retained.
- When `out_valid`=0, `out_data` and `out_last` are forced to 0.
- Read port: `data_out` <= `mem[address]` on every edge. It returns 0 when `address` ≥ N·N. On a write/read collision at the same index, the old data is returned.

## Timing
- Reset values:
  - state LOAD; `in_ready`=1 (follows state)
  - `out_valid`=0, `out_last`=0, `out_data`=0
  - `full`=0, `busy`=0
  - `trace`=0, `data_out`=0
  - all memory = 0
- Accepting the final input word in cycle t gives `full`=1 in t+1. `trace` is final in t+1.
- `start` in cycle t gives `out_valid`=1 with element 0 in t+1.
- With `out_ready` held high, one word transfers per cycle. A full replay takes N·N cycles (N in mode 2). After the last handshake, `in_ready`=1 on the next cycle.
- `data_out` latency is 1 cycle from `address`.
- Asserting `reset` mid-load or mid-stream asynchronously forces all reset values. There is no partial output.
- `in_valid` while `in_ready`=0 is ignored; no word is lost or stored.

## Test plan
- Reset, then load 1..25 (N=5) with `in_valid` always high → `full`=1 the cycle after word 25. `trace`=1+7+13+19+25=65. `address`=12 gives `data_out`=13 one cycle later.
- `start`, mode 0, `out_ready`=1 → 25 consecutive words 1..25, `out_last` only on 25. `in_ready`=1 the next cycle and `trace`=0.
- Mode 1 with `out_ready` toggling 1,0,1,0 → sequence 1,6,11,16,21,2,7,… ending at 25. `out_data` is stable during every stall cycle.
- Mode 2 → 1,7,13,19,25 with `out_last` on 25. Mode 3 replays as row-major.
- `clear` at word 3 of a STREAM → `out_valid`=0 next cycle, state LOAD. Reloading 25 words of 0xFFFFFFFF gives `trace` = 5·(2^32−1) mod 2^35 = 0x4FFFFFFFB.
- `reset` asserted mid-load after 10 words → all outputs at reset values immediately. `address`=3 gives `data_out`=0.

Source files
------------

// File: rtl/la_matrix_stream_if.sv
// Stream bundle for la_matrix_stream: row-major load stream in, replay stream out.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface la_matrix_stream_if #(
  parameter int unsigned W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/la_matrix_stream.sv
// N x N matrix buffer: loads a row-major stream while accumulating the trace, then replays it
// row-major, transposed or diagonal-only. A registered random-access read port is always live.
module la_matrix_stream #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  la_matrix_stream_if.slave   bus,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                full,
  output logic                busy,
  output logic [W+TW-1:0]     trace,
  input  logic [AW-1:0]       address,
  output logic [W-1:0]        data_out
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastRc  = CW'(N - 1);
  localparam logic [AW-1:0] NStride = AW'(N);
  localparam logic [AW-1:0] DStride = AW'(N + 1);
  localparam logic [AW-1:0] LastPtr = AW'(NN - 1);
  localparam logic [AW:0]   NnExt   = (AW + 1)'(NN);

  typedef enum logic [1:0] {StLoad, StFull, StStream} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d;
  logic [CW-1:0]     rd_r_q, rd_r_d, rd_c_q, rd_c_d;
  logic [1:0]        mode_q, mode_d;
  logic [W+TW-1:0]   trace_q, trace_d;
  logic [W-1:0]      data_out_q, data_out_d;
  logic [W-1:0]      mem_q [NN];
  logic [W-1:0]      mem_d [NN];
  logic [AW-1:0]     rd_idx;
  logic              last_word;

  // Mode 3 is reserved and decodes as row-major.
  always_comb begin
    rd_idx = '0;
    case (mode_q)
      2'd1:    rd_idx = AW'(rd_c_q) * NStride + AW'(rd_r_q);
      2'd2:    rd_idx = AW'(rd_r_q) * DStride;
      default: rd_idx = AW'(rd_r_q) * NStride + AW'(rd_c_q);
    endcase
  end

  assign last_word = (mode_q == 2'd2) ? (rd_r_q == LastRc)
                                      : ((rd_r_q == LastRc) && (rd_c_q == LastRc));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    row_d    = row_q;
    col_d    = col_q;
    rd_r_d   = rd_r_q;
    rd_c_d   = rd_c_q;
    mode_d   = mode_q;
    trace_d  = trace_q;
    mem_d    = mem_q;

    if (clear) begin
      state_d  = StLoad;
      wr_ptr_d = '0;
      row_d    = '0;
      col_d    = '0;
      rd_r_d   = '0;
      rd_c_d   = '0;
      trace_d  = '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (bus.in_valid) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (row_q == col_q) trace_d = trace_q + (W + TW)'(bus.in_data);
            if (col_q == LastRc) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            if (wr_ptr_q == LastPtr) begin
              state_d = StFull;
              row_d   = '0;
              col_d   = '0;
            end
          end
        end
        StFull: begin
          if (start) begin
            state_d = StStream;
            mode_d  = mode;
            rd_r_d  = '0;
            rd_c_d  = '0;
          end
        end
        StStream: begin
          if (bus.out_ready) begin
            if (last_word) begin
              state_d  = StLoad;
              wr_ptr_d = '0;
              trace_d  = '0;
            end else if (mode_q == 2'd2) begin
              rd_r_d = rd_r_q + CW'(1);
            end else if (rd_c_q == LastRc) begin
              rd_c_d = '0;
              rd_r_d = rd_r_q + CW'(1);
            end else begin
              rd_c_d = rd_c_q + CW'(1);
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // Reads the pre-write array, so a same-index write returns the old word.
  always_comb begin
    data_out_d = '0;
    if ({1'b0, address} < NnExt) data_out_d = mem_q[address];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      wr_ptr_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rd_r_q     <= '0;
      rd_c_q     <= '0;
      mode_q     <= '0;
      trace_q    <= '0;
      data_out_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_r_q     <= rd_r_d;
      rd_c_q     <= rd_c_d;
      mode_q     <= mode_d;
      trace_q    <= trace_d;
      data_out_q <= data_out_d;
      mem_q      <= mem_d;
    end
  end

  assign busy          = (state_q == StStream);
  assign full          = (state_q != StLoad);
  assign trace         = trace_q;
  assign data_out      = data_out_q;
  assign bus.in_ready  = (state_q == StLoad);
  assign bus.out_valid = busy;
  assign bus.out_data  = busy ? mem_q[rd_idx] : '0;
  assign bus.out_last  = busy & last_word;

endmodule

// File: tb/tb_la_matrix_stream.sv
// Scoreboard bench for la_matrix_stream (N=5, W=32): expected replay words are queued at start
// and popped on each output handshake.
module tb_la_matrix_stream;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        start;
  logic [1:0]  mode;
  logic        full;
  logic        busy;
  logic [34:0] trace;
  logic [4:0]  address;
  logic [31:0] data_out;

  la_matrix_stream_if #(.W(32)) bus ();

  la_matrix_stream #(.N(5), .W(32), .AW(5), .TW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .bus      (bus),
    .start    (start),
    .mode     (mode),
    .full     (full),
    .busy     (busy),
    .trace    (trace),
    .address  (address),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [25];
  logic [32:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] model_trace();
    logic [34:0] s = '0;
    for (int k = 0; k < 5; k++) s = s + 35'(model[k * 6]);
    return s;
  endfunction

  // Loads count words: 1..count, or all-ones.
  task automatic load_matrix(input bit ones, input int count);
    for (int i = 0; i < count; i++) begin
      model[i]     = ones ? 32'hFFFF_FFFF : 32'(i + 1);
      bus.in_valid = 1'b1;
      bus.in_data  = model[i];
      @(posedge clk);
      #1;
      if (i == 23) check_eq("full_before_last", 64'(full), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic replay(input logic [1:0] m, input bit toggle, input int max_fires,
                        output int cycles);
    int len;
    int idx;
    int fires;
    len = (m == 2'd2) ? 5 : 25;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      if (m == 2'd1)      idx = (k % 5) * 5 + k / 5;
      else if (m == 2'd2) idx = k * 6;
      else                idx = k;
      exp_q.push_back({(k == len - 1), model[idx]});
    end
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mode   = 2'd0;
    fires  = 0;
    cycles = 0;
    while (exp_q.size() > 0 && fires < max_fires && cycles < 200) begin
      bus.out_ready = toggle ? ~cycles[0] : 1'b1;
      check_eq("out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("out_data", 64'(bus.out_data), 64'(exp_q[0][31:0]));
      check_eq("out_last", 64'(bus.out_last), 64'(exp_q[0][32]));
      @(posedge clk);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        fires++;
      end
      #1;
      cycles++;
    end
    bus.out_ready = 1'b0;
    if (cycles >= 200) check_eq("replay_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    check_eq({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check_eq({tag, "_full"}, 64'(full), 64'd0);
    check_eq({tag, "_trace"}, 64'(trace), 64'd0);
  endtask

  initial begin
    int cyc;
    reset         = 1'b0;
    clear         = 1'b0;
    start         = 1'b0;
    mode          = 2'd0;
    address       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;
    check_idle("reset");
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_data_out", 64'(data_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load 1..25, then random-access reads.
    load_matrix(1'b0, 25);
    check_eq("full_after_load", 64'(full), 64'd1);
    check_eq("in_ready_full", 64'(bus.in_ready), 64'd0);
    check_eq("trace_load", 64'(trace), 64'd65);
    check_eq("trace_model", 64'(trace), 64'(model_trace()));
    address = 5'd12;
    @(posedge clk);
    #1;
    check_eq("data_out_12", 64'(data_out), 64'(model[12]));
    address = 5'd25;
    @(posedge clk);
    #1;
    check_eq("data_out_oob", 64'(data_out), 64'd0);

    // Words offered while FULL must be dropped.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd999;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("full_hold", 64'(full), 64'd1);

    replay(2'd0, 1'b0, 1000, cyc);
    check_eq("mode0_cycles", 64'(cyc), 64'd25);
    check_idle("after_mode0");

    load_matrix(1'b0, 25);
    replay(2'd1, 1'b1, 1000, cyc);
    check_eq("mode1_cycles", 64'(cyc), 64'd49);
    check_idle("after_mode1");

    load_matrix(1'b0, 25);
    replay(2'd2, 1'b0, 1000, cyc);
    check_eq("mode2_cycles", 64'(cyc), 64'd5);
    check_idle("after_mode2");

    load_matrix(1'b0, 25);
    replay(2'd3, 1'b0, 1000, cyc);
    check_eq("mode3_cycles", 64'(cyc), 64'd25);

    // Abort a replay at word 3; memory must survive the clear.
    load_matrix(1'b0, 25);
    replay(2'd0, 1'b0, 3, cyc);
    check_eq("pre_clear_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_idle("after_clear");
    check_eq("clear_busy", 64'(busy), 64'd0);
    address = 5'd5;
    @(posedge clk);
    #1;
    check_eq("retained_5", 64'(data_out), 64'd6);
    load_matrix(1'b1, 25);
    check_eq("trace_ones", 64'(trace), 64'h4_FFFF_FFFB);
    check_eq("trace_ones_model", 64'(trace), 64'(model_trace()));
    replay(2'd2, 1'b0, 1000, cyc);

    // Asynchronous reset in the middle of a load.
    load_matrix(1'b0, 10);
    #3;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    check_eq("async_reset_busy", 64'(busy), 64'd0);
    check_eq("async_reset_data_out", 64'(data_out), 64'd0);
    address = 5'd3;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("data_out_after_reset", 64'(data_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
